// File: rtl/input_16.sv
// input_16: framing stage ahead of the 16-bit calculator.
// Collects an opcode and two 16-bit operands from the tagged 10-bit host bus.
// When a frame is complete it issues a one-cycle start, then holds off new
// frames until the calculator reports done_calc.
module input_16 #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  data_in,
    input  logic        done_calc,
    output logic [7:0]  opcode,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic        start,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        A_LO,
        B_HI,
        B_LO,
        ISSUE,
        WAIT_DONE
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       payload;
    logic [1:0]       tag;
    logic [7:0]       op_shadow;
    logic [7:0]       a_hi_shadow;
    logic [7:0]       a_lo_shadow;
    logic [7:0]       b_hi_shadow;
    logic [CNT_W-1:0] gap_cnt;
    logic             err_set;
    logic             gap_clr;
    logic             gap_inc;
    logic             load_op;
    logic             load_a_hi;
    logic             load_a_lo;
    logic             load_b_hi;
    logic             issue_load;

    assign payload = data_in[9:2];
    assign tag     = data_in[1:0];

    // Next-state decode plus the strobes that steer shadow loads, gap counting and errors.
    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        load_op    = 1'b0;
        load_a_hi  = 1'b0;
        load_a_lo  = 1'b0;
        load_b_hi  = 1'b0;
        issue_load = 1'b0;
        case (state)
            IDLE: begin
                if (tag == 2'b01) begin
                    load_op    = 1'b1;
                    gap_clr    = 1'b1;
                    next_state = A_HI;
                end else if (tag == 2'b11) begin
                    err_set = 1'b1;
                end
            end
            A_HI, A_LO, B_HI, B_LO: begin
                case (tag)
                    2'b11: begin
                        gap_clr = 1'b1;
                        case (state)
                            A_HI: begin
                                load_a_hi  = 1'b1;
                                next_state = A_LO;
                            end
                            A_LO: begin
                                load_a_lo  = 1'b1;
                                next_state = B_HI;
                            end
                            B_HI: begin
                                load_b_hi  = 1'b1;
                                next_state = B_LO;
                            end
                            default: begin
                                issue_load = 1'b1;
                                next_state = ISSUE;
                            end
                        endcase
                    end
                    2'b00: begin
                        if (gap_cnt >= GAP_LIMIT) begin
                            err_set    = 1'b1;
                            gap_clr    = 1'b1;
                            next_state = IDLE;
                        end else begin
                            gap_inc = 1'b1;
                        end
                    end
                    2'b01: begin
                        load_op    = 1'b1;
                        gap_clr    = 1'b1;
                        err_set    = 1'b1;
                        next_state = A_HI;
                    end
                    default: begin
                        gap_clr    = 1'b1;
                        next_state = IDLE;
                    end
                endcase
            end
            ISSUE: begin
                err_set    = tag[0];
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                err_set = tag[0];
                if (done_calc) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Consecutive idle-tag counter used for the mid-frame timeout; it saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (gap_clr) begin
            gap_cnt <= '0;
        end else if (gap_inc && (gap_cnt != '1)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Shadow registers that hold the frame fields while it is still arriving.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_shadow   <= '0;
            a_hi_shadow <= '0;
            a_lo_shadow <= '0;
            b_hi_shadow <= '0;
        end else begin
            if (load_op) begin
                op_shadow <= payload;
            end
            if (load_a_hi) begin
                a_hi_shadow <= payload;
            end
            if (load_a_lo) begin
                a_lo_shadow <= payload;
            end
            if (load_b_hi) begin
                b_hi_shadow <= payload;
            end
        end
    end

    // Issued fields load on the edge entering ISSUE; the final byte bypasses its shadow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode    <= '0;
            operand_a <= '0;
            operand_b <= '0;
        end else if (issue_load) begin
            opcode    <= op_shadow;
            operand_a <= {a_hi_shadow, a_lo_shadow};
            operand_b <= {b_hi_shadow, payload};
        end
    end

    // Registered handshake and error outputs, derived from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            start     <= (next_state == ISSUE);
            busy      <= (next_state == ISSUE) || (next_state == WAIT_DONE);
            frame_err <= err_set;
            if (err_set && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
